// File: rtl/mips_id_stage_if.sv
// mips_id_stage_if
//   Bundles every non-clock signal of the MIPS ID stage: the IF/ID handshake,
//   register-file read port, EX/MEM/WB forwarding taps and the ID/EX outputs.
//   Parameters: AWL (register address width), DWL (data width, >= 16).
//   Modports:
//     slave  - the ID stage itself (consumes instruction/taps, drives ID/EX)
//     master - the surrounding pipeline (drives instruction/taps, reads ID/EX)
interface mips_id_stage_if #(
    parameter int AWL = 5,
    parameter int DWL = 32
);
    logic           id_valid;
    logic [31:0]    id_instr;
    logic           id_stall;
    logic           flush;
    logic           ex_ready;
    logic [AWL-1:0] RA1;
    logic [AWL-1:0] RA2;
    logic [DWL-1:0] RD1;
    logic [DWL-1:0] RD2;
    logic [DWL-1:0] ex_result;
    logic           mem_reg_write;
    logic           mem_is_load;
    logic [AWL-1:0] mem_dest;
    logic [DWL-1:0] mem_result;
    logic           wb_wen;
    logic [AWL-1:0] wb_wa;
    logic [DWL-1:0] wb_wd;
    logic           ex_valid;
    logic [5:0]     ex_opcode;
    logic [5:0]     ex_funct;
    logic [DWL-1:0] ex_rs_val;
    logic [DWL-1:0] ex_rt_val;
    logic [DWL-1:0] ex_imm;
    logic [AWL-1:0] ex_dest;
    logic           ex_reg_write;
    logic           ex_is_load;

    modport slave (
        input  id_valid, id_instr, flush, ex_ready, RD1, RD2, ex_result,
        input  mem_reg_write, mem_is_load, mem_dest, mem_result,
        input  wb_wen, wb_wa, wb_wd,
        output id_stall, RA1, RA2,
        output ex_valid, ex_opcode, ex_funct, ex_rs_val, ex_rt_val, ex_imm,
        output ex_dest, ex_reg_write, ex_is_load
    );

    modport master (
        output id_valid, id_instr, flush, ex_ready, RD1, RD2, ex_result,
        output mem_reg_write, mem_is_load, mem_dest, mem_result,
        output wb_wen, wb_wa, wb_wd,
        input  id_stall, RA1, RA2,
        input  ex_valid, ex_opcode, ex_funct, ex_rs_val, ex_rt_val, ex_imm,
        input  ex_dest, ex_reg_write, ex_is_load
    );
endinterface

// File: rtl/mips_id_stage.sv
// mips_id_stage
//   MIPS instruction-decode / operand-fetch stage. Drives the register-file
//   read addresses, resolves RAW hazards (EX/MEM/WB forwarding, load-use
//   stalls) and registers the decoded instruction into the ID/EX register.
//   Ports:
//     clk  - clock
//     rst  - asynchronous reset, active-high; clears the whole ID/EX entry
//     bus  - mips_id_stage_if.slave: IF/ID handshake, RF read port,
//            forwarding taps and ID/EX outputs
//   Build option:
//     ID_FORWARD_EN - when defined, non-load results in EX and MEM are
//                     forwarded; when undefined, any matching register write
//                     in EX or MEM stalls ID. The WB bypass is always present.
module mips_id_stage #(
    parameter int AWL = 5,
    parameter int DWL = 32
) (
    input  logic           clk,
    input  logic           rst,
    mips_id_stage_if.slave bus
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;

    logic [5:0]            w_opcode_p0;
    logic [5:0]            w_funct_p0;
    logic [AWL-1:0]        w_rs_p0;
    logic [AWL-1:0]        w_rt_p0;
    logic [AWL-1:0]        w_rd_p0;
    logic [AWL-1:0]        w_dest_p0;
    logic                  w_reg_write_p0;
    logic                  w_is_load_p0;
    logic signed [DWL-1:0] w_imm_p0;
    logic [DWL-1:0]        w_rs_val_p0;
    logic [DWL-1:0]        w_rt_val_p0;
    logic                  w_ex_fwd;
    logic                  w_mem_fwd;
    logic                  w_ex_haz;
    logic                  w_mem_haz;
    logic                  w_hazard;
    logic                  w_hold;

    logic                  r_vld_p1;
    logic [5:0]            r_opcode_p1;
    logic [5:0]            r_funct_p1;
    logic [DWL-1:0]        r_rs_val_p1;
    logic [DWL-1:0]        r_rt_val_p1;
    logic signed [DWL-1:0] r_imm_p1;
    logic [AWL-1:0]        r_dest_p1;
    logic                  r_reg_write_p1;
    logic                  r_is_load_p1;

    function automatic logic signed [DWL-1:0] f_sext16(input logic [15:0] v);
        return DWL'(signed'(v));
    endfunction

    // A producer matches a source only for a real (non-$0) register.
    function automatic logic f_hit(input logic [AWL-1:0] s, input logic en,
                                   input logic [AWL-1:0] dest);
        return en && (s != '0) && (s == dest);
    endfunction

    function automatic logic [DWL-1:0] f_resolve(
        input logic [AWL-1:0] s,      input logic [DWL-1:0] rf_val,
        input logic           ex_hit, input logic           mem_hit,
        input logic           wb_hit, input logic [DWL-1:0] ex_val,
        input logic [DWL-1:0] mem_val, input logic [DWL-1:0] wb_val);
        if (s == '0)  return '0;
        if (ex_hit)   return ex_val;
        if (mem_hit)  return mem_val;
        // The RF only shows the WB write after this edge, so bypass it here.
        if (wb_hit)   return wb_val;
        return rf_val;
    endfunction

    // ---- stage p0: decode and operand resolution (combinational) ----
    assign w_opcode_p0 = bus.id_instr[31:26];
    assign w_funct_p0  = bus.id_instr[5:0];
    assign w_rs_p0     = bus.id_instr[25:21];
    assign w_rt_p0     = bus.id_instr[20:16];
    assign w_rd_p0     = bus.id_instr[15:11];
    assign w_imm_p0    = f_sext16(bus.id_instr[15:0]);
    assign bus.RA1     = w_rs_p0;
    assign bus.RA2     = w_rt_p0;

    always_comb begin
        w_dest_p0      = '0;
        w_reg_write_p0 = 1'b0;
        w_is_load_p0   = 1'b0;
        if (w_opcode_p0 == OP_RTYPE) begin
            w_dest_p0      = w_rd_p0;
            w_reg_write_p0 = (w_funct_p0 != FN_JR);
        end else if (w_opcode_p0 >= 6'h08 && w_opcode_p0 <= 6'h0F) begin
            w_dest_p0      = w_rt_p0;
            w_reg_write_p0 = 1'b1;
        end else if (w_opcode_p0 >= 6'h20 && w_opcode_p0 <= 6'h25) begin
            w_dest_p0      = w_rt_p0;
            w_reg_write_p0 = 1'b1;
            w_is_load_p0   = 1'b1;
        end else if (w_opcode_p0 == OP_JAL) begin
            w_dest_p0      = AWL'(31);
            w_reg_write_p0 = 1'b1;
        end
        if (w_dest_p0 == '0) begin
            w_reg_write_p0 = 1'b0;
        end
    end

`ifdef ID_FORWARD_EN
    assign w_ex_fwd  = r_vld_p1 && r_reg_write_p1 && !r_is_load_p1;
    assign w_mem_fwd = bus.mem_reg_write && !bus.mem_is_load;
    assign w_ex_haz  = r_vld_p1 && r_reg_write_p1 && r_is_load_p1;
    assign w_mem_haz = bus.mem_reg_write && bus.mem_is_load;
`else
    // Without forwarding every in-flight write to a source must drain to WB.
    assign w_ex_fwd  = 1'b0;
    assign w_mem_fwd = 1'b0;
    assign w_ex_haz  = r_vld_p1 && r_reg_write_p1;
    assign w_mem_haz = bus.mem_reg_write;
`endif

    assign w_rs_val_p0 = f_resolve(w_rs_p0, bus.RD1,
                                   f_hit(w_rs_p0, w_ex_fwd, r_dest_p1),
                                   f_hit(w_rs_p0, w_mem_fwd, bus.mem_dest),
                                   f_hit(w_rs_p0, bus.wb_wen, bus.wb_wa),
                                   bus.ex_result, bus.mem_result, bus.wb_wd);
    assign w_rt_val_p0 = f_resolve(w_rt_p0, bus.RD2,
                                   f_hit(w_rt_p0, w_ex_fwd, r_dest_p1),
                                   f_hit(w_rt_p0, w_mem_fwd, bus.mem_dest),
                                   f_hit(w_rt_p0, bus.wb_wen, bus.wb_wa),
                                   bus.ex_result, bus.mem_result, bus.wb_wd);

    assign w_hazard = bus.id_valid &&
                      (f_hit(w_rs_p0, w_ex_haz, r_dest_p1)     ||
                       f_hit(w_rt_p0, w_ex_haz, r_dest_p1)     ||
                       f_hit(w_rs_p0, w_mem_haz, bus.mem_dest) ||
                       f_hit(w_rt_p0, w_mem_haz, bus.mem_dest));
    assign w_hold   = r_vld_p1 && !bus.ex_ready;
    // A flush discards the ID instruction, so IF/ID is free to advance.
    assign bus.id_stall = !bus.flush && (w_hold || w_hazard);

    // ---- stage p1: ID/EX register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1       <= 1'b0;
            r_opcode_p1    <= '0;
            r_funct_p1     <= '0;
            r_rs_val_p1    <= '0;
            r_rt_val_p1    <= '0;
            r_imm_p1       <= '0;
            r_dest_p1      <= '0;
            r_reg_write_p1 <= 1'b0;
            r_is_load_p1   <= 1'b0;
        end else if (bus.flush) begin
            r_vld_p1 <= 1'b0;
        end else if (w_hold) begin
            r_vld_p1 <= r_vld_p1;
        end else if (w_hazard) begin
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1       <= bus.id_valid;
            r_opcode_p1    <= w_opcode_p0;
            r_funct_p1     <= w_funct_p0;
            r_rs_val_p1    <= w_rs_val_p0;
            r_rt_val_p1    <= w_rt_val_p0;
            r_imm_p1       <= w_imm_p0;
            r_dest_p1      <= w_dest_p0;
            r_reg_write_p1 <= w_reg_write_p0;
            r_is_load_p1   <= w_is_load_p0;
        end
    end

    assign bus.ex_valid     = r_vld_p1;
    assign bus.ex_opcode    = r_opcode_p1;
    assign bus.ex_funct     = r_funct_p1;
    assign bus.ex_rs_val    = r_rs_val_p1;
    assign bus.ex_rt_val    = r_rt_val_p1;
    assign bus.ex_imm       = r_imm_p1;
    assign bus.ex_dest      = r_dest_p1;
    assign bus.ex_reg_write = r_reg_write_p1;
    assign bus.ex_is_load   = r_is_load_p1;
endmodule

// File: tb/tb_mips_id_stage.sv
// tb_mips_id_stage
//   Bench for mips_id_stage. Surrounds the DUT with a register file, an EX
//   stage and MEM/WB stages, and compares every ID/EX entry against the
//   architectural register state of sequential MIPS execution.
module tb_mips_id_stage;
    localparam int AWL = 5;
    localparam int DWL = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mips_id_stage_if #(.AWL(AWL), .DWL(DWL)) bus();
    mips_id_stage #(.AWL(AWL), .DWL(DWL)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] rf   [32];
    logic [31:0] arch [32];
    logic [31:0] te_res;

    assign bus.RD1       = rf[bus.RA1];
    assign bus.RD2       = rf[bus.RA2];
    assign bus.ex_result = te_res;

    // Downstream pipeline (MEM, WB) and the entry expected in EX.
    logic        m_wen, m_ld, w_wen;
    logic [4:0]  m_dest, w_wa;
    logic [31:0] m_res, w_wd;
    logic        te_valid, te_wr, te_ld;
    logic [4:0]  te_dest;
    logic [31:0] te_rs, te_rt, te_imm;

    logic [31:0] prog[$];
    int pc;
    int stalls;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ldata(input logic [31:0] a);
        return 32'hDEADBEEF ^ a;
    endfunction

    function automatic logic [31:0] simm(input logic [31:0] ins);
        return {{16{ins[15]}}, ins[15:0]};
    endfunction

    function automatic void ref_dec(input logic [31:0] ins, output logic [4:0] d,
                                    output logic wr, output logic ld);
        int op;
        op = int'(ins[31:26]);
        d = 5'd0; wr = 1'b0; ld = 1'b0;
        if (op == 0) begin d = ins[15:11]; wr = (ins[5:0] != 6'h08); end
        else if (op >= 8 && op <= 15) begin d = ins[20:16]; wr = 1'b1; end
        else if (op >= 32 && op <= 37) begin d = ins[20:16]; wr = 1'b1; ld = 1'b1; end
        else if (op == 3) begin d = 5'd31; wr = 1'b1; end
        if (d == 5'd0) wr = 1'b0;
    endfunction

    function automatic logic [31:0] alu(input logic [31:0] ins, input logic [31:0] a,
                                        input logic [31:0] b);
        int op;
        op = int'(ins[31:26]);
        if (op == 0) return a + b;
        if (op >= 8 && op <= 15) return a + simm(ins);
        if (op >= 32 && op <= 37) return a + simm(ins);
        if (op == 3) return 32'h0000_0100;
        return 32'h0;
    endfunction

    function automatic bit hitf(input logic [4:0] s, input logic [4:0] d);
        return (s != 5'd0) && (s == d);
    endfunction

    function automatic logic [31:0] i_addi(input int rt, input int rs, input int imm);
        return {6'h08, 5'(rs), 5'(rt), 16'(imm)};
    endfunction
    function automatic logic [31:0] i_add(input int rd, input int rs, input int rt);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h20};
    endfunction
    function automatic logic [31:0] i_lw(input int rt, input int rs, input int imm);
        return {6'h23, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic drive_ds();
        bus.mem_reg_write = m_wen;
        bus.mem_is_load   = m_ld;
        bus.mem_dest      = m_dest;
        bus.mem_result    = m_res;
        bus.wb_wen        = w_wen;
        bus.wb_wa         = w_wa;
        bus.wb_wd         = w_wd;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) begin rf[i] = 32'h0; arch[i] = 32'h0; end
        m_wen = 0; m_ld = 0; m_dest = 0; m_res = 0;
        w_wen = 0; w_wa = 0; w_wd = 0;
        te_valid = 0; te_wr = 0; te_ld = 0; te_dest = 0;
        te_rs = 0; te_rt = 0; te_imm = 0; te_res = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.id_valid = 1'b0; bus.id_instr = 32'h0; bus.flush = 1'b0; bus.ex_ready = 1'b1;
        clear_model();
        drive_ds();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_prog(input int rdy_pct, input int vld_pct, input int max_cyc);
        int cyc;
        logic [4:0] rs, rt, d;
        logic hold, haz, exp_stall, accept, wr, ld;
        logic nm_wen, nm_ld, nw_wen;
        logic [4:0] nm_dest, nw_wa;
        logic [31:0] nm_res, nw_wd, ins;
        cyc = 0; stalls = 0; pc = 0;
        while ((pc < prog.size() || te_valid || m_wen || w_wen) && cyc < max_cyc) begin
            cyc++;
            @(negedge clk);
            bus.flush    = 1'b0;
            bus.id_valid = (pc < prog.size()) && ($urandom_range(99) < vld_pct);
            bus.id_instr = (pc < prog.size()) ? prog[pc] : 32'h0;
            bus.ex_ready = ($urandom_range(99) < rdy_pct);
            #1;
            rs   = bus.id_instr[25:21];
            rt   = bus.id_instr[20:16];
            hold = te_valid && !bus.ex_ready;
`ifdef ID_FORWARD_EN
            haz = (te_valid && te_wr && te_ld && (hitf(rs, te_dest) || hitf(rt, te_dest))) ||
                  (m_wen && m_ld && (hitf(rs, m_dest) || hitf(rt, m_dest)));
`else
            haz = (te_valid && te_wr && (hitf(rs, te_dest) || hitf(rt, te_dest))) ||
                  (m_wen && (hitf(rs, m_dest) || hitf(rt, m_dest)));
`endif
            exp_stall = hold || (bus.id_valid && haz);
            chk("id_stall", bus.id_stall, exp_stall);
            if (bus.id_stall) stalls++;
            accept  = !hold && bus.id_valid && !haz;
            nm_wen  = te_valid && !hold && te_wr;
            nm_ld   = te_valid && !hold && te_ld;
            nm_dest = te_dest;
            nm_res  = te_res;
            nw_wen  = m_wen;
            nw_wa   = m_dest;
            nw_wd   = m_ld ? ldata(m_res) : m_res;
            ins     = bus.id_instr;
            @(posedge clk);
            #1;
            if (w_wen && w_wa != 5'd0) rf[w_wa] = w_wd;
            m_wen = nm_wen; m_ld = nm_ld; m_dest = nm_dest; m_res = nm_res;
            w_wen = nw_wen; w_wa = nw_wa; w_wd = nw_wd;
            if (!hold) begin
                if (accept) begin
                    pc++;
                    ref_dec(ins, d, wr, ld);
                    te_valid = 1'b1; te_dest = d; te_wr = wr; te_ld = ld;
                    te_rs  = arch[ins[25:21]];
                    te_rt  = arch[ins[20:16]];
                    te_imm = simm(ins);
                    te_res = alu(ins, te_rs, te_rt);
                    if (wr) arch[d] = ld ? ldata(te_res) : te_res;
                    chk("ex_rs_val", bus.ex_rs_val, te_rs);
                    chk("ex_rt_val", bus.ex_rt_val, te_rt);
                    chk("ex_imm", bus.ex_imm, te_imm);
                    chk("ex_opcode", bus.ex_opcode, ins[31:26]);
                    chk("ex_funct", bus.ex_funct, ins[5:0]);
                    chk("ex_reg_write", bus.ex_reg_write, wr);
                    chk("ex_is_load", bus.ex_is_load, ld);
                    if (wr) chk("ex_dest", bus.ex_dest, d);
                end else begin
                    te_valid = 1'b0;
                end
            end
            drive_ds();
            chk("ex_valid", bus.ex_valid, te_valid);
        end
        if (cyc >= max_cyc) chk("run_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.id_valid = 1'b0; bus.id_instr = 32'h0; bus.flush = 1'b0; bus.ex_ready = 1'b1;
        clear_model();
        drive_ds();
        #2;
        chk("reset_ex_valid", bus.ex_valid, 0);
        chk("reset_ex_rs_val", bus.ex_rs_val, 0);

        // Independent immediates: no stall.
        do_reset();
        prog = '{i_addi(1, 0, 5), i_addi(2, 0, 7)};
        run_prog(100, 100, 50);
        chk("stalls_indep", stalls, 0);

        // Dependent ALU op right behind its producer.
        do_reset();
        prog = '{i_addi(1, 0, 5), i_add(3, 1, 2)};
        run_prog(100, 100, 50);
`ifdef ID_FORWARD_EN
        chk("stalls_ex_dep", stalls, 0);
`else
        chk("stalls_ex_dep", stalls, 2);
`endif

        // Load-use: two bubbles, then the WB value feeds both operands.
        do_reset();
        prog = '{i_lw(4, 0, 0), i_add(5, 4, 4)};
        run_prog(100, 100, 50);
        chk("stalls_load_use", stalls, 2);

        // Reader in ID while the producer writes back in the same cycle.
        do_reset();
        prog = '{i_addi(6, 0, 16'h1234), 32'h0, 32'h0, i_add(7, 6, 0)};
        run_prog(100, 100, 50);
        chk("stalls_wb_bypass", stalls, 0);

        // Randomized instruction mix with EX back-pressure and IF bubbles.
        do_reset();
        prog.delete();
        for (int i = 0; i < 400; i++) begin
            int k;
            logic [4:0] a, b, c;
            k = $urandom_range(9);
            a = 5'($urandom_range(7)); b = 5'($urandom_range(7)); c = 5'($urandom_range(7));
            if (k <= 2)      prog.push_back({6'($urandom_range(15, 8)), a, b, 16'($urandom)});
            else if (k <= 5) prog.push_back({6'h00, a, b, c, 5'($urandom),
                                             ($urandom_range(7) == 0) ? 6'h08 : 6'($urandom)});
            else if (k <= 7) prog.push_back({6'($urandom_range(37, 32)), a, b, 16'($urandom_range(255))});
            else if (k == 8) prog.push_back({6'h03, 26'($urandom)});
            else             prog.push_back({6'h2B, a, b, 16'($urandom)});
        end
        run_prog(75, 85, 6000);

        // Asynchronous reset with a live ID/EX entry.
        do_reset();
        @(negedge clk);
        rf[3] = 32'h55;
        bus.id_instr = i_lw(9, 3, 16'h8005); bus.id_valid = 1'b1; bus.ex_ready = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_valid", bus.ex_valid, 1);
        chk("pre_rst_imm", bus.ex_imm, 32'hFFFF8005);
        chk("pre_rst_rs_val", bus.ex_rs_val, 32'h55);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_ex_valid", bus.ex_valid, 0);
        chk("rst_ex_opcode", bus.ex_opcode, 0);
        chk("rst_ex_funct", bus.ex_funct, 0);
        chk("rst_ex_rs_val", bus.ex_rs_val, 0);
        chk("rst_ex_rt_val", bus.ex_rt_val, 0);
        chk("rst_ex_imm", bus.ex_imm, 0);
        chk("rst_ex_dest", bus.ex_dest, 0);
        chk("rst_ex_reg_write", bus.ex_reg_write, 0);
        chk("rst_ex_is_load", bus.ex_is_load, 0);
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        drive_ds();
        bus.id_instr = i_addi(1, 0, 5); bus.id_valid = 1'b1; bus.ex_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_valid", bus.ex_valid, 1);
        chk("post_rst_imm", bus.ex_imm, 5);

        // WB writing $0 must not leak into a $0 read.
        do_reset();
        @(negedge clk);
        bus.wb_wen = 1'b1; bus.wb_wa = 5'd0; bus.wb_wd = 32'd9;
        bus.id_instr = i_add(8, 0, 0); bus.id_valid = 1'b1; bus.ex_ready = 1'b1;
        @(posedge clk); #1;
        chk("wb_r0_rs_val", bus.ex_rs_val, 0);
        chk("wb_r0_rt_val", bus.ex_rt_val, 0);

        // Flush over a pending load-use hazard and a held EX entry.
        do_reset();
        @(negedge clk);
        bus.id_instr = i_lw(4, 0, 0); bus.id_valid = 1'b1; bus.ex_ready = 1'b1;
        @(posedge clk); #1;
        chk("flush_setup_valid", bus.ex_valid, 1);
        @(negedge clk);
        bus.id_instr = i_add(5, 4, 4); bus.ex_ready = 1'b0; bus.flush = 1'b0;
        #1;
        chk("flush_pre_stall", bus.id_stall, 1);
        bus.flush = 1'b1;
        #1;
        chk("flush_stall", bus.id_stall, 0);
        @(posedge clk); #1;
        chk("flush_ex_valid", bus.ex_valid, 0);
        bus.flush = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_id_stage.md
Name: mips_id_stage

Overview:
- MIPS instruction-decode / operand-fetch stage. Sits directly upstream of the register file and drives its read addresses.
- Consumes the register file's asynchronous-read data and resolves RAW hazards: forwarding from EX, MEM and WB, plus load-use stalls.
- Registers the decoded operands into the ID/EX pipeline register that feeds the execute stage.

Parameters:
AWL, 5, register address width
DWL, 32, data width; must be at least 16

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
id_valid  in  1  instr holds a valid instruction
id_instr  in  32  instruction word from IF/ID
id_stall  out  1  IF/ID must hold (combinational)
flush  in  1  kill the instruction in ID; load a bubble
ex_ready  in  1  EX accepts a new ID/EX entry this cycle
RA1  out  AWL  RF read address = instr[25:21] (rs)
RA2  out  AWL  RF read address = instr[20:16] (rt)
RD1  in  DWL  RF read data 1
RD2  in  DWL  RF read data 2
ex_result  in  DWL  combinational ALU result of the current ID/EX entry
mem_reg_write  in  1  MEM-stage instruction writes a register
mem_is_load  in  1  MEM-stage instruction is a load
mem_dest  in  AWL  MEM-stage destination
mem_result  in  DWL  MEM-stage ALU result
wb_wen  in  1  WB write enable; same bus as RF wen
wb_wa  in  AWL  WB address; same as RF WA
wb_wd  in  DWL  WB data; same as RF WD
ex_valid  out  1  ID/EX entry valid
ex_opcode  out  6  instr[31:26]
ex_funct  out  6  instr[5:0]
ex_rs_val  out  DWL  resolved rs operand
ex_rt_val  out  DWL  resolved rt operand
ex_imm  out  DWL  sign-extended instr[15:0]
ex_dest  out  AWL  destination register
ex_reg_write  out  1  entry writes a register
ex_is_load  out  1  entry is a load

Behaviour:
- Reset: every ex_* output is 0, including ex_valid.
- Decode (opcode):
  - 0x00: dest = rd. reg_write = 1 unless funct = 0x08 (JR).
  - 0x08–0x0F: dest = rt, reg_write = 1.
  - 0x20–0x25: dest = rt, reg_write = 1, is_load = 1.
  - 0x03 (JAL): dest = 31, reg_write = 1.
  - All other opcodes: reg_write = 0.
  - reg_write is forced to 0 whenever dest = 0.
- Operand resolution, per source register s, in priority order:
  - s = 0 → 0.
  - ID/EX valid && reg_write && dest = s && !is_load → ex_result.
  - mem_reg_write && mem_dest = s && !mem_is_load → mem_result.
  - wb_wen && wb_wa = s → wb_wd. This covers the same-cycle write that the RF does not yet show.
  - Otherwise RD1/RD2.
- Load-use hazard: id_valid, and a matching s (≠ 0) with ID/EX is_load, or with mem_is_load && mem_reg_write.
- Hold condition: ex_valid && !ex_ready.
- Priority at each posedge: rst > flush > hold > hazard > normal.
  - flush: ex_valid ← 0. id_stall = 0.
  - hold: ID/EX unchanged. id_stall = 1.
  - hazard: ex_valid ← 0 (bubble). id_stall = 1.
  - normal: ID/EX ← decoded instruction. ex_valid ← id_valid. id_stall = 0.
- id_stall is a combinational function of the current inputs and state. It is 0 when flush = 1.
- Latency: 1 cycle from ID to EX with no hazard. Load-use penalty: 2 bubbles with the load in EX, 1 with the load in MEM.
- Reset mid-operation clears the ID/EX entry immediately.

Optional Feature:
- Macro: ID_FORWARD_EN.
- Defined: EX and MEM forwarding as described above.
- Undefined:
  - No EX or MEM forwarding.
  - Any matching register write in EX or MEM (load or not) is treated as a hazard.
  - The WB bypass and the RF path are kept.

Test Plan:
- rst asserted mid-stream → all ex_* = 0 asynchronously. After release, first valid instruction gives ex_valid = 1 one cycle later.
- Independent ops: addi $1,$0,5 then addi $2,$0,7 → ex_rs_val = 0, ex_imm = 5 then 7, no stall.
- add $3,$1,$2 directly after addi $1 with ex_result = 5 → ex_rs_val = 5 with no stall. With ID_FORWARD_EN undefined → 2 stall cycles.
- lw $4 followed by add $5,$4,$4 → id_stall = 1 for 2 cycles, ex_valid = 0 twice. On resolution, wb_wd = 0xDEADBEEF forwarded to both operands.
- WB writes $6 = 0x1234 in the same cycle ID reads $6 while RD1 = 0 → ex_rs_val = 0x1234. A read of $0 while WB writes $0 = 9 → 0.
- flush asserted with a load-use hazard pending and ex_ready = 0 → ex_valid ← 0, id_stall = 0 that cycle.
